// File: rtl/qtcore_scan_sequencer.sv
// Drives the qtcore scan/proc pins: LOAD shifts host bytes into the chain, RUN clocks the core, DUMP recirculates the chain out as bytes.
// Latency: shifting starts the cycle after a byte handshake; in_ready/out_ready backpressure stalls the chain (scan_enable low).
module qtcore_scan_sequencer #(
  parameter int CHAIN_LEN   = 128,
  parameter int RUN_TIMEOUT = 4096,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             run_start,
  input  logic             dump_start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  input  logic             out_ready,
  input  logic             scan_out_in,
  input  logic             halt_in,
  output logic             scan_enable,
  output logic             scan_in,
  output logic             proc_en,
  output logic             busy,
  output logic             timeout,
  output logic [CNT_W-1:0] run_cycles
);

  localparam int BIT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CHAIN_LEN - 1);
  localparam logic [BIT_W-1:0] ALL_BITS = BIT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DUMP = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;

  // sh_byte serves both directions: MSB feeds scan_in on LOAD, scan_out_in enters the LSB on DUMP
  logic [7:0]       sh_byte;
  logic             ld_full;
  logic [2:0]       bit_cnt;
  logic [BIT_W-1:0] bit_total;

  logic             load_shift;
  logic             dump_shift;
  logic             load_hs;
  logic             byte_end;
  logic             run_hit;
  logic             dump_done;
  logic             run_accept;

  assign load_shift = (state == S_LOAD) && ld_full;
  assign dump_shift = (state == S_DUMP) && (bit_total != ALL_BITS) && (!out_valid || out_ready);
  assign load_hs    = in_valid && in_ready;
  assign byte_end   = (bit_cnt == 3'd7);
  assign run_hit    = (state == S_RUN) && (run_cycles == RUN_LAST);
  assign dump_done  = (state == S_DUMP) && (bit_total == ALL_BITS) && out_valid && out_ready;
  assign run_accept = (state == S_IDLE) && (state_nxt == S_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_start) begin
            state_nxt = S_LOAD;
          end else if (run_start) begin
            state_nxt = S_RUN;
          end else if (dump_start) begin
            state_nxt = S_DUMP;
          end
        end
        S_LOAD: begin
          if (load_shift && (bit_total == LAST_BIT)) begin
            state_nxt = S_IDLE;
          end
        end
        S_RUN: begin
          if (halt_in || run_hit) begin
            state_nxt = S_IDLE;
          end
        end
        S_DUMP: begin
          if (dump_done) begin
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // The next byte is taken on the 8th shift so back-to-back bytes stream without a bubble
  always_comb begin
    scan_enable = 1'b0;
    scan_in     = 1'b0;
    proc_en     = 1'b0;
    in_ready    = 1'b0;
    busy        = (state != S_IDLE);
    case (state)
      S_LOAD: begin
        scan_enable = load_shift;
        scan_in     = load_shift && sh_byte[7];
        in_ready    = !ld_full || (byte_end && (bit_total != LAST_BIT));
      end
      S_RUN: begin
        proc_en = 1'b1;
      end
      S_DUMP: begin
        scan_enable = dump_shift;
        scan_in     = dump_shift && scan_out_in;
      end
      default: begin
        scan_enable = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_byte   <= '0;
      ld_full   <= 1'b0;
      bit_cnt   <= '0;
      bit_total <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (state_nxt == S_IDLE) begin
      // completion, abort and idle all leave the byte path empty for the next operation
      sh_byte   <= '0;
      ld_full   <= 1'b0;
      bit_cnt   <= '0;
      bit_total <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (load_shift || dump_shift) begin
        sh_byte   <= {sh_byte[6:0], dump_shift && scan_out_in};
        bit_cnt   <= bit_cnt + 3'd1;
        bit_total <= bit_total + 1'b1;
      end
      if (load_hs) begin
        sh_byte <= in_data;
        ld_full <= 1'b1;
      end else if (load_shift && byte_end) begin
        ld_full <= 1'b0;
      end
      if (dump_shift && byte_end) begin
        out_data  <= {sh_byte[6:0], scan_out_in};
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // halt on the final allowed cycle still reports a clean stop, not a timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cycles <= '0;
      timeout    <= 1'b0;
    end else if (run_accept) begin
      run_cycles <= '0;
      timeout    <= 1'b0;
    end else if (proc_en) begin
      if (run_cycles != {CNT_W{1'b1}}) begin
        run_cycles <= run_cycles + 1'b1;
      end
      if (halt_in) begin
        timeout <= 1'b0;
      end else if (run_hit) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule
